// File: rtl/vx_raster_stamp_receiver_pkg.sv
// Shared raster types for the socket-side stamp receiver: stamp layout, packet and
// response widths, and the small helpers the receiver logic uses.
package vx_raster_stamp_receiver_pkg;

    localparam int NUM_LANES  = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_WIDTH  = 8;
    localparam int PERF_WIDTH = 32;

    // Stamp fields as packed by the cluster rasterizer: x/y position, primitive id, 3 barycentrics.
    localparam int POS_W    = 16;
    localparam int PID_W    = 16;
    localparam int BCOORD_W = 16;

    localparam int STAMP_WIDTH = 2 * POS_W + PID_W + 3 * BCOORD_W;

    typedef struct packed {
        logic [3*BCOORD_W-1:0] bcoords;
        logic [PID_W-1:0]      pid;
        logic [POS_W-1:0]      pos_y;
        logic [POS_W-1:0]      pos_x;
    } raster_stamp_t;

    typedef logic [NUM_LANES*STAMP_WIDTH-1:0] stamp_vec_t;
    typedef logic [NUM_LANES-1:0]             lane_mask_t;
    typedef logic [TAG_WIDTH-1:0]             tag_t;

    typedef struct packed {
        lane_mask_t mask;
        stamp_vec_t stamps;
    } raster_pkt_t;

    localparam int PKT_WIDTH = $bits(raster_pkt_t);

    function automatic logic pkt_has_stamps(input lane_mask_t mask);
        return |mask;
    endfunction

endpackage

// File: rtl/vx_raster_stamp_receiver_if.sv
// Raster bus (cluster -> socket), warp fetch request/response and perf counter, bundled
// so the receiver and its driver agree on one port list.
interface vx_raster_stamp_receiver_if;
    import vx_raster_stamp_receiver_pkg::*;

    // Handshakes: a transfer happens in the cycle where valid && ready are both high;
    // ready may depend combinationally on valid-side state, valid never depends on ready.
    logic       frame_start;

    logic       raster_req_valid;
    stamp_vec_t raster_req_stamps;
    lane_mask_t raster_req_mask;
    logic       raster_req_done;
    logic       raster_req_ready;

    logic       fetch_valid;
    tag_t       fetch_tag;
    logic       fetch_ready;

    logic       rsp_valid;
    tag_t       rsp_tag;
    stamp_vec_t rsp_stamps;
    lane_mask_t rsp_mask;
    logic       rsp_done;
    logic       rsp_ready;

    logic [PERF_WIDTH-1:0] perf_stall_cycles;

    modport master (
        output frame_start,
        output raster_req_valid, raster_req_stamps, raster_req_mask, raster_req_done,
        input  raster_req_ready,
        output fetch_valid, fetch_tag,
        input  fetch_ready,
        input  rsp_valid, rsp_tag, rsp_stamps, rsp_mask, rsp_done,
        output rsp_ready,
        input  perf_stall_cycles
    );

    modport slave (
        input  frame_start,
        input  raster_req_valid, raster_req_stamps, raster_req_mask, raster_req_done,
        output raster_req_ready,
        input  fetch_valid, fetch_tag,
        output fetch_ready,
        output rsp_valid, rsp_tag, rsp_stamps, rsp_mask, rsp_done,
        input  rsp_ready,
        output perf_stall_cycles
    );

endinterface

// File: rtl/vx_raster_stamp_receiver_fifo.sv
// Generic power-of-two packet FIFO with synchronous clear; head is visible on data_out
// whenever empty is low.
module vx_raster_stamp_receiver_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one wrap bit so full and empty are distinguishable without a counter.
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_out = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = data_in;
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vx_raster_stamp_receiver.sv
// Socket-side raster stamp receiver: buffers stamp packets from the cluster rasterizer and
// answers warp fetches with one registered response, flagging end-of-draw once drained.
module vx_raster_stamp_receiver
    import vx_raster_stamp_receiver_pkg::*;
(
    input logic                       clk,
    input logic                       reset,
    vx_raster_stamp_receiver_if.slave bus
);
    raster_pkt_t push_pkt;
    raster_pkt_t head_pkt;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_push;
    logic        fifo_pop;

    logic req_ready;
    logic req_fire;
    logic fetch_ready;
    logic fetch_fire;
    logic rsp_free;

    logic                  done_q, done_d;
    logic                  rsp_valid_q, rsp_valid_d;
    tag_t                  rsp_tag_q, rsp_tag_d;
    stamp_vec_t            rsp_stamps_q, rsp_stamps_d;
    lane_mask_t            rsp_mask_q, rsp_mask_d;
    logic                  rsp_done_q, rsp_done_d;
    logic [PERF_WIDTH-1:0] perf_q, perf_d;

    assign push_pkt = '{mask: bus.raster_req_mask, stamps: bus.raster_req_stamps};

    // No push bypass when full: a same-cycle pop does not make room until the next cycle.
    assign req_ready = !fifo_full && !bus.frame_start;
    assign req_fire  = bus.raster_req_valid && req_ready;
    assign fifo_push = req_fire && pkt_has_stamps(bus.raster_req_mask);

    assign rsp_free    = !rsp_valid_q || bus.rsp_ready;
    assign fetch_ready = rsp_free && (!fifo_empty || done_q) && !bus.frame_start;
    assign fetch_fire  = bus.fetch_valid && fetch_ready;
    assign fifo_pop    = fetch_fire && !fifo_empty;

    vx_raster_stamp_receiver_fifo #(
        .DATA_WIDTH (PKT_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (bus.frame_start),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .data_in  (push_pkt),
        .data_out (head_pkt),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        // done_r only sees req_done through req_fire, which frame_start already masks.
        done_d = done_q;
        if (bus.frame_start) begin
            done_d = 1'b0;
        end else if (req_fire && bus.raster_req_done) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_stamps_d = rsp_stamps_q;
        rsp_mask_d   = rsp_mask_q;
        rsp_done_d   = rsp_done_q;
        if (fetch_fire) begin
            rsp_valid_d = 1'b1;
            rsp_tag_d   = bus.fetch_tag;
            if (!fifo_empty) begin
                rsp_stamps_d = head_pkt.stamps;
                rsp_mask_d   = head_pkt.mask;
                rsp_done_d   = 1'b0;
            end else begin
                rsp_stamps_d = '0;
                rsp_mask_d   = '0;
                rsp_done_d   = 1'b1;
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (bus.fetch_valid && !fetch_ready) begin
            perf_d = perf_q + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_stamps_q <= '0;
            rsp_mask_q   <= '0;
            rsp_done_q   <= 1'b0;
            perf_q       <= '0;
        end else begin
            done_q       <= done_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_stamps_q <= rsp_stamps_d;
            rsp_mask_q   <= rsp_mask_d;
            rsp_done_q   <= rsp_done_d;
            perf_q       <= perf_d;
        end
    end

    assign bus.raster_req_ready  = req_ready;
    assign bus.fetch_ready       = fetch_ready;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_tag           = rsp_tag_q;
    assign bus.rsp_stamps        = rsp_stamps_q;
    assign bus.rsp_mask          = rsp_mask_q;
    assign bus.rsp_done          = rsp_done_q;
    assign bus.perf_stall_cycles = perf_q;

endmodule

// File: tb/tb_vx_raster_stamp_receiver.sv
// Bench for the raster stamp receiver: directed scenarios followed by random traffic, all
// checked against a packet-queue model of the buffer, done flag and response slot.
module tb_vx_raster_stamp_receiver;
    import vx_raster_stamp_receiver_pkg::*;

    localparam int SW    = NUM_LANES * STAMP_WIDTH;
    localparam int PKT_W = NUM_LANES + SW;
    localparam int RSP_W = TAG_WIDTH + NUM_LANES + SW + 1;
    typedef logic [RSP_W-1:0] wide_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vx_raster_stamp_receiver_if bus();

    vx_raster_stamp_receiver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: buffered packets {mask,stamps}, sticky done, outstanding response, stall count.
    logic [PKT_W-1:0] pkt_q[$];
    logic [RSP_W-1:0] exp_q[$];
    logic             done_m = 1'b0;
    logic             pending_m = 1'b0;
    logic [31:0]      stall_m = '0;
    logic             hold_v = 1'b0;
    logic [RSP_W-1:0] hold_rsp = '0;
    logic [4:0]       obs_log[$];
    logic             last_req_acc = 1'b0;
    logic             last_fetch_acc = 1'b0;

    task automatic chk(input string tag, input wide_t obs, input wide_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic wide_t cur_rsp();
        return {bus.rsp_tag, bus.rsp_mask, bus.rsp_stamps, bus.rsp_done};
    endfunction

    function automatic stamp_vec_t rand_stamps();
        stamp_vec_t s;
        for (int i = 0; i < SW / 32; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    task automatic idle_inputs();
        bus.frame_start       = 1'b0;
        bus.raster_req_valid  = 1'b0;
        bus.raster_req_stamps = '0;
        bus.raster_req_mask   = '0;
        bus.raster_req_done   = 1'b0;
        bus.fetch_valid       = 1'b0;
        bus.fetch_tag         = '0;
        bus.rsp_ready         = 1'b1;
    endtask

    // One clock: entered 1 time unit after a rising edge with inputs driven; checks, advances model.
    task automatic cycle();
        logic [PKT_W-1:0] p;
        logic exp_req_ready, exp_fetch_ready, fa, ra;
        #1;
        exp_req_ready   = (pkt_q.size() < FIFO_DEPTH) && !bus.frame_start;
        exp_fetch_ready = (!pending_m || bus.rsp_ready) && (pkt_q.size() != 0 || done_m) && !bus.frame_start;
        chk("raster_req_ready", wide_t'(bus.raster_req_ready), wide_t'(exp_req_ready));
        chk("fetch_ready", wide_t'(bus.fetch_ready), wide_t'(exp_fetch_ready));
        chk("rsp_valid", wide_t'(bus.rsp_valid), wide_t'(pending_m));
        chk("perf_stall_cycles", wide_t'(bus.perf_stall_cycles), wide_t'(stall_m));
        if (hold_v) chk("rsp_hold_stable", cur_rsp(), hold_rsp);
        if (pending_m && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", wide_t'(bus.rsp_valid), wide_t'(1'b0));
            end else begin
                chk("rsp_content", cur_rsp(), exp_q.pop_front());
                obs_log.push_back({bus.rsp_done, bus.rsp_mask});
            end
        end
        hold_v   = pending_m && !bus.rsp_ready;
        hold_rsp = cur_rsp();

        fa = bus.fetch_valid && exp_fetch_ready;
        ra = bus.raster_req_valid && exp_req_ready;
        if (bus.fetch_valid && !exp_fetch_ready) stall_m++;
        if (fa) begin
            if (pkt_q.size() != 0) begin
                p = pkt_q.pop_front();
                exp_q.push_back({bus.fetch_tag, p, 1'b0});
            end else begin
                exp_q.push_back({bus.fetch_tag, {PKT_W{1'b0}}, 1'b1});
            end
        end
        if (bus.frame_start) begin
            pkt_q.delete();
            done_m = 1'b0;
        end else if (ra) begin
            if (bus.raster_req_mask != '0) pkt_q.push_back({bus.raster_req_mask, bus.raster_req_stamps});
            if (bus.raster_req_done) done_m = 1'b1;
        end
        pending_m      = fa || (pending_m && !bus.rsp_ready);
        last_req_acc   = ra;
        last_fetch_acc = fa;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_pkt(input logic [3:0] mask, input logic done);
        bus.raster_req_valid  = 1'b1;
        bus.raster_req_mask   = mask;
        bus.raster_req_done   = done;
        bus.raster_req_stamps = rand_stamps();
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (last_req_acc) break;
        end
        chk("raster_req_accept_timeout", wide_t'(last_req_acc), wide_t'(1'b1));
        bus.raster_req_valid = 1'b0;
        bus.raster_req_done  = 1'b0;
    endtask

    task automatic fetch_one();
        bus.fetch_valid = 1'b1;
        bus.fetch_tag   = TAG_WIDTH'($urandom);
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (last_fetch_acc) break;
        end
        chk("fetch_accept_timeout", wide_t'(last_fetch_acc), wide_t'(1'b1));
        bus.fetch_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        bus.frame_start = 1'b1;
        cycle();
        bus.frame_start = 1'b0;
    endtask

    task automatic check_log(input string tag, input int n,
                             input logic [4:0] e0, input logic [4:0] e1,
                             input logic [4:0] e2, input logic [4:0] e3);
        logic [4:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_count"}, wide_t'(obs_log.size()), wide_t'(n));
        for (int i = 0; i < n && i < obs_log.size(); i++) chk(tag, wide_t'(obs_log[i]), wide_t'(e[i]));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately.
    task automatic apply_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("reset_rsp_fields", cur_rsp(), '0);
        chk("reset_rsp_valid", wide_t'(bus.rsp_valid), wide_t'(1'b0));
        chk("reset_perf", wide_t'(bus.perf_stall_cycles), '0);
        chk("reset_raster_req_ready", wide_t'(bus.raster_req_ready), wide_t'(1'b1));
        chk("reset_fetch_ready", wide_t'(bus.fetch_ready), wide_t'(1'b0));
        idle_inputs();
        pkt_q.delete();
        exp_q.delete();
        done_m    = 1'b0;
        pending_m = 1'b0;
        stall_m   = '0;
        hold_v    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        apply_reset();

        // Three packets then a bare done: fetches see F, 3, 1 and then end-of-draw.
        obs_log.delete();
        send_pkt(4'hF, 1'b0);
        send_pkt(4'h3, 1'b0);
        send_pkt(4'h1, 1'b0);
        send_pkt(4'h0, 1'b1);
        repeat (4) fetch_one();
        idle(2);
        check_log("order_and_done", 4, 5'h0F, 5'h03, 5'h01, 5'h10);

        // Fill the buffer with fetch idle, then one pop frees a slot.
        pulse_frame();
        for (int i = 0; i < FIFO_DEPTH; i++) send_pkt(4'($urandom_range(1, 15)), 1'b0);
        chk("full_ready_low", wide_t'(bus.raster_req_ready), wide_t'(1'b0));
        fetch_one();
        chk("ready_after_pop", wide_t'(bus.raster_req_ready), wide_t'(1'b1));
        repeat (FIFO_DEPTH - 1) fetch_one();
        idle(2);

        // Stall on an empty buffer for 5 cycles, packet arrives on the fifth.
        apply_reset();
        bus.fetch_valid = 1'b1;
        bus.fetch_tag   = 8'h5A;
        idle(4);
        bus.raster_req_valid  = 1'b1;
        bus.raster_req_mask   = 4'hA;
        bus.raster_req_stamps = rand_stamps();
        cycle();
        bus.raster_req_valid = 1'b0;
        cycle();
        bus.fetch_valid = 1'b0;
        chk("stall_fetch_accepted", wide_t'(last_fetch_acc), wide_t'(1'b1));
        chk("stall_count", wide_t'(bus.perf_stall_cycles), wide_t'(32'd5));
        chk("rsp_latency_valid", wide_t'(bus.rsp_valid), wide_t'(1'b1));
        chk("rsp_latency_mask", wide_t'(bus.rsp_mask), wide_t'(4'hA));
        idle(2);

        // Consumer back-pressure for 3 cycles.
        send_pkt(4'h6, 1'b0);
        send_pkt(4'h9, 1'b0);
        bus.rsp_ready   = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_tag   = 8'hC3;
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("backpressure_fetch_ready", wide_t'(bus.fetch_ready), wide_t'(1'b0));
            cycle();
        end
        bus.rsp_ready = 1'b1;
        cycle();
        bus.fetch_valid = 1'b0;
        idle(2);

        // Done riding on a packet with stamps.
        pulse_frame();
        obs_log.delete();
        send_pkt(4'h5, 1'b1);
        fetch_one();
        fetch_one();
        idle(2);
        check_log("done_with_stamps", 2, 5'h05, 5'h10, 5'h00, 5'h00);

        // frame_start drops buffered packets and done; fetch waits for the new draw.
        send_pkt(4'h3, 1'b0);
        send_pkt(4'hC, 1'b0);
        send_pkt(4'h0, 1'b1);
        pulse_frame();
        bus.fetch_valid = 1'b1;
        bus.fetch_tag   = 8'h77;
        idle(3);
        chk("post_frame_fetch_stall", wide_t'(bus.fetch_ready), wide_t'(1'b0));
        send_pkt(4'h7, 1'b0);
        cycle();
        bus.fetch_valid = 1'b0;
        idle(2);

        // Reset in the middle of a burst.
        bus.raster_req_valid  = 1'b1;
        bus.raster_req_mask   = 4'hB;
        bus.raster_req_stamps = rand_stamps();
        bus.fetch_valid       = 1'b1;
        idle(3);
        apply_reset();
        idle(1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bus.frame_start       = ($urandom_range(0, 39) == 0);
            bus.raster_req_valid  = 1'($urandom_range(0, 1));
            bus.raster_req_mask   = 4'($urandom_range(0, 15));
            bus.raster_req_done   = ($urandom_range(0, 15) == 0);
            bus.raster_req_stamps = rand_stamps();
            bus.fetch_valid       = ($urandom_range(0, 2) != 0);
            bus.fetch_tag         = TAG_WIDTH'($urandom);
            bus.rsp_ready         = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle_inputs();
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
